// File: rtl/serial_pkg.sv
// Shared definitions for the serial stb/ack <-> UART blocks (state encoding, divider math, frame sizes).
// Used by serial_output now and by the future serial_input receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_t;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_NO_PARITY = 10;
  localparam int FRAME_BITS_PARITY    = 11;

  // Clock cycles per bit time; integer division truncates toward zero.
  function automatic int baud_divider(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic int frame_bits(input bit parity_en);
    return parity_en ? FRAME_BITS_PARITY : FRAME_BITS_NO_PARITY;
  endfunction

  // Accept-to-accept spacing when the producer keeps the stream full.
  function automatic int min_frame_spacing(input int divider, input bit parity_en);
    return frame_bits(parity_en) * divider + 1;
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-time counter: counts 0..DIVIDER-1 and pulses tick on the last count.
// restart holds the counter at zero so a new bit period begins cleanly.
module serial_baud_tick #(
  parameter int DIVIDER = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST_COUNT) && !restart;

endmodule

// File: rtl/serial_output.sv
// stb/ack word sink that transmits the low byte of each word as a UART frame on tx.
// Define SERIAL_OUTPUT_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module serial_output
  import serial_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int PARITY_ODD      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_serial,
  input  logic        input_serial_stb,
  output logic        input_serial_ack,
  output logic        tx
);

  localparam int DIVIDER = baud_divider(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  serial_state_t state, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          tx_next;
  logic          ack_next;
  logic          tick;
  logic          unused_bits;

`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam logic PARITY_SENSE = (PARITY_ODD != 0);
  logic parity_bit, parity_next;

  assign unused_bits = ^input_serial[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_bit <= 1'b0;
    end else begin
      parity_bit <= parity_next;
    end
  end
`else
  assign unused_bits = ^{input_serial[15:8], PARITY_ODD != 0};
`endif

  // The counter sits at zero in IDLE so START always gets a full bit time.
  serial_baud_tick #(
    .DIVIDER(DIVIDER)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(state == ST_IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      shift_reg        <= '0;
      bit_idx          <= '0;
      tx               <= 1'b1;
      input_serial_ack <= 1'b0;
    end else begin
      state            <= state_next;
      shift_reg        <= shift_next;
      bit_idx          <= bit_idx_next;
      tx               <= tx_next;
      input_serial_ack <= ack_next;
    end
  end

  // tx is computed one cycle ahead and registered so the line never glitches.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    ack_next     = 1'b0;
`ifdef SERIAL_OUTPUT_PARITY_EN
    parity_next  = parity_bit;
`endif
    case (state)
      ST_IDLE: begin
        tx_next      = 1'b1;
        bit_idx_next = '0;
        if (input_serial_stb && !input_serial_ack) begin
          ack_next   = 1'b1;
          tx_next    = 1'b0;
          shift_next = input_serial[7:0];
`ifdef SERIAL_OUTPUT_PARITY_EN
          parity_next = (^input_serial[7:0]) ^ PARITY_SENSE;
`endif
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_OUTPUT_PARITY_EN
            tx_next    = parity_bit;
            state_next = ST_PARITY;
`else
            tx_next    = 1'b1;
            state_next = ST_STOP;
`endif
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef SERIAL_OUTPUT_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tx_next    = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
